// File: rtl/accelerator_matrix_vector_feeder.sv
// accelerator_matrix_vector_feeder: streams a row-major matrix and then a vector from one source onto strobed A/B outputs
// ports: clk, rst_n (asynchronous, active-low); start/ready = transfer request and one-cycle completion pulse;
//   size_a_i/size_a_j/size_b = matrix rows, matrix columns and vector length, latched on an accepted start;
//   src_valid/src_ready/src_data = upstream word stream; data_a_i_enable = matrix word opens a new row;
//   data_a_j_enable/data_a = matrix word strobe and data; data_b_enable/data_b = vector word strobe and data
module accelerator_matrix_vector_feeder #(
   parameter int DATA_SIZE    = 64,
   parameter int CONTROL_SIZE = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   output logic                 ready,
   input  logic [DATA_SIZE-1:0] size_a_i,
   input  logic [DATA_SIZE-1:0] size_a_j,
   input  logic [DATA_SIZE-1:0] size_b,
   input  logic                 src_valid,
   output logic                 src_ready,
   input  logic [DATA_SIZE-1:0] src_data,
   output logic                 data_a_i_enable,
   output logic                 data_a_j_enable,
   output logic                 data_b_enable,
   output logic [DATA_SIZE-1:0] data_a,
   output logic [DATA_SIZE-1:0] data_b
);
   typedef enum logic [1:0] {IDLE, MATRIX, VECTOR} state_t;
   localparam logic [DATA_SIZE-1:0] ONE = 1;
   state_t state;
   logic [DATA_SIZE-1:0] si, sj, sb, i, j, b;
   // CONTROL_SIZE carries no logic; it only has to describe a real width
   if (CONTROL_SIZE < 1) begin : g_control_size_invalid
   end
   assign src_ready = state != IDLE;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         si              <= '0;
         sj              <= '0;
         sb              <= '0;
         i               <= '0;
         j               <= '0;
         b               <= '0;
         ready           <= 1'b0;
         data_a_i_enable <= 1'b0;
         data_a_j_enable <= 1'b0;
         data_b_enable   <= 1'b0;
         data_a          <= '0;
         data_b          <= '0;
      end else begin
         ready           <= 1'b0;
         data_a_i_enable <= 1'b0;
         data_a_j_enable <= 1'b0;
         data_b_enable   <= 1'b0;
         case (state)
            IDLE: if (start) begin
               si    <= size_a_i;
               sj    <= size_a_j;
               sb    <= size_b;
               i     <= '0;
               j     <= '0;
               b     <= '0;
               state <= (size_a_i != '0 && size_a_j != '0) ? MATRIX : (size_b != '0) ? VECTOR : IDLE;
               // an empty transfer completes immediately
               ready <= (size_a_i == '0 || size_a_j == '0) && size_b == '0;
            end
            MATRIX: if (src_valid) begin
               data_a          <= src_data;
               data_a_j_enable <= 1'b1;
               data_a_i_enable <= j == '0;
               j               <= (j == sj - ONE) ? '0 : j + ONE;
               if (j == sj - ONE) begin
                  i <= i + ONE;
                  if (i == si - ONE) begin
                     state <= (sb != '0) ? VECTOR : IDLE;
                     ready <= sb == '0;
                  end
               end
            end
            VECTOR: if (src_valid) begin
               data_b        <= src_data;
               data_b_enable <= 1'b1;
               b             <= b + ONE;
               if (b == sb - ONE) begin
                  state <= IDLE;
                  ready <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
